// File: rtl/sig_deser.sv
// Probe capture front end: synchronises sig, samples it every DIV clocks and
// packs 32 samples per word (oldest in bit 0) for the measurement block.
// A square-wave pattern generator can replace the probe, switched per word.
module sig_deser #(
  parameter int unsigned DIV         = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig,
  input  logic        tp_en,
  input  logic [15:0] tp_half,
  output logic [31:0] dsq0,
  output logic        pclk,
  output logic        wvalid
);

  typedef enum logic [0:0] {StFill, StRun} state_e;

  localparam logic [15:0] DivMax = 16'(DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [15:0]            div_cnt_q;
  logic                   stb;
  logic [4:0]             bit_cnt_q;
  logic                   word_end;
  logic                   mid_word;
  logic                   tp_act_q;
  logic                   tp_bit_q;
  logic [15:0]            tp_cnt_q;
  logic [15:0]            tp_hm1;
  logic                   tp_start;
  logic                   src;
  logic [31:0]            shreg_q;
  logic [31:0]            shift_d;
  logic [31:0]            dsq_q;
  logic                   pclk_q;
  state_e                 state_q, state_d;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign stb      = (div_cnt_q == DivMax);
  assign word_end = stb && (bit_cnt_q == 5'd31);
  assign mid_word = stb && (bit_cnt_q == 5'd15);
  // A half period of 0 behaves as 1.
  assign tp_hm1   = (tp_half == 16'd0) ? 16'd0 : tp_half - 16'd1;
  assign tp_start = word_end && tp_en && !tp_act_q;
  assign src      = tp_act_q ? tp_bit_q : sync_out;
  assign shift_d  = {src, shreg_q[31:1]};

  // Metastability synchroniser on the probe input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else if (SYNC_STAGES > 1) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
    end else begin
      sync_q <= sig;
    end
  end

  // Sample strobe divider: one stb every DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (stb) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 16'd1;
    end
  end

  // Test-pattern generator; source selection only changes at word boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_act_q <= 1'b0;
      tp_bit_q <= 1'b0;
      tp_cnt_q <= '0;
    end else if (stb) begin
      if (word_end) begin
        tp_act_q <= tp_en;
      end
      if (tp_start) begin
        tp_bit_q <= 1'b1;
        tp_cnt_q <= '0;
      end else if (tp_act_q) begin
        // >= so a live reduction of tp_half takes effect at once.
        if (tp_cnt_q >= tp_hm1) begin
          tp_bit_q <= ~tp_bit_q;
          tp_cnt_q <= '0;
        end else begin
          tp_cnt_q <= tp_cnt_q + 16'd1;
        end
      end
    end
  end

  // Shift register, bit counter, word latch and word clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dsq_q     <= '0;
      pclk_q    <= 1'b0;
    end else if (stb) begin
      shreg_q   <= shift_d;
      bit_cnt_q <= bit_cnt_q + 5'd1;
      if (word_end) begin
        dsq_q  <= shift_d;
        pclk_q <= 1'b1;
      end else if (mid_word) begin
        pclk_q <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave FILL once the first word is complete.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (word_end) state_d = StRun;
      StRun:  state_d = StRun;
      default: state_d = StFill;
    endcase
  end

  // FSM outputs: hold the word interface quiet until the first word exists.
  always_comb begin
    dsq0   = '0;
    pclk   = 1'b0;
    wvalid = 1'b0;
    unique case (state_q)
      StFill: begin
        dsq0   = '0;
        pclk   = 1'b0;
        wvalid = 1'b0;
      end
      StRun: begin
        dsq0   = dsq_q;
        pclk   = pclk_q;
        wvalid = 1'b1;
      end
      default: begin
        dsq0   = '0;
        pclk   = 1'b0;
        wvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sig_deser.sv
// Self-checking bench for sig_deser: directed test-plan steps followed by a
// random phase, all compared every cycle against a sample-stream model.
module tb_sig_deser;

  localparam int DIV = 4;
  localparam int S   = 3;

  logic        clk;
  logic        rst;
  logic        sig;
  logic        tp_en;
  logic [15:0] tp_half;
  logic [31:0] dsq0;
  logic        pclk;
  logic        wvalid;

  int total;
  int bad;

  // Model state: sample stream view of the capture path.
  bit          hist[$];
  int          cyc;
  int          n;
  bit          cur_tp;
  bit          nxt_tp;
  bit          prev_tp;
  bit          level;
  int          run_len;
  logic [31:0] wbuf;
  logic [31:0] exp_dsq;

  sig_deser #(
    .DIV         (DIV),
    .SYNC_STAGES (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sig     (sig),
    .tp_en   (tp_en),
    .tp_half (tp_half),
    .dsq0    (dsq0),
    .pclk    (pclk),
    .wvalid  (wvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    cyc     = 0;
    n       = 0;
    cur_tp  = 1'b0;
    nxt_tp  = 1'b0;
    prev_tp = 1'b0;
    level   = 1'b0;
    run_len = 0;
    wbuf    = '0;
    exp_dsq = '0;
  endtask

  // One clock of the model; called right after a rising edge with rst low.
  task automatic model_tick();
    bit probe;
    bit v;
    int pos;
    int half;
    hist.push_back(sig);
    if (hist.size() > 8) void'(hist.pop_front());
    cyc++;
    if (cyc % DIV == 0) begin
      // The sample sees sig as it was S rising edges earlier.
      probe = (hist.size() > S) ? hist[hist.size() - 1 - S] : 1'b0;
      pos   = n % 32;
      if (pos == 0) begin
        prev_tp = cur_tp;
        cur_tp  = (n == 0) ? 1'b0 : nxt_tp;
        if (cur_tp && !prev_tp) begin
          level   = 1'b1;
          run_len = 0;
        end
      end
      v = cur_tp ? level : probe;
      if (cur_tp) begin
        half = (tp_half == 16'd0) ? 1 : int'(tp_half);
        run_len++;
        if (run_len >= half) begin
          level   = ~level;
          run_len = 0;
        end
      end
      wbuf[pos] = v;
      n++;
      if (pos == 31) begin
        nxt_tp  = tp_en;
        exp_dsq = wbuf;
      end
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = (n >= 32);
    chk("dsq0", dsq0, ev ? exp_dsq : 32'h0);
    chk("pclk", {31'h0, pclk}, {31'h0, ev && ((n % 32) < 16)});
    chk("wvalid", {31'h0, wvalid}, {31'h0, ev});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int samples);
    repeat (samples * DIV) step();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    sig     = 1'b0;
    tp_en   = 1'b1;
    tp_half = 16'd16;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dsq0", dsq0, 32'h0);
    chk("rst_pclk", {31'h0, pclk}, 32'h0);
    chk("rst_wvalid", {31'h0, wvalid}, 32'h0);
    rst = 1'b0;

    // Pattern with half period 16, then 4, 1 and 0.
    run(96);
    chk("tp16", dsq0, 32'h0000FFFF);
    tp_half = 16'd4;
    run(64);
    chk("tp4", dsq0, 32'h0F0F0F0F);
    tp_half = 16'd1;
    run(64);
    chk("tp1", dsq0, 32'h55555555);
    tp_half = 16'd0;
    run(32);
    chk("tp0", dsq0, 32'h55555555);

    // Probe path: steady high, then a mid-word fall.
    tp_en = 1'b0;
    sig   = 1'b1;
    run(96);
    chk("probe_hi", dsq0, 32'hFFFFFFFF);
    run(10);
    sig = 1'b0;
    run(22);
    chk("probe_mixed", dsq0, 32'h000003FF);
    run(32);
    chk("probe_lo", dsq0, 32'h0);

    // Enable raised mid-word only affects the following word.
    run(10);
    tp_en = 1'b1;
    run(22);
    chk("tp_midword", dsq0, 32'h0);
    run(32);
    chk("tp_nextword", dsq0, 32'h55555555);

    // Asynchronous reset while pclk is high.
    run(10);
    chk("pre_rst_pclk", {31'h0, pclk}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_pclk", {31'h0, pclk}, 32'h0);
    chk("async_dsq0", dsq0, 32'h0);
    chk("async_wvalid", {31'h0, wvalid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (32 * DIV - 1) step();
    chk("first_word_pre", {31'h0, wvalid}, 32'h0);
    step();
    chk("first_word_post", {31'h0, wvalid}, 32'h1);

    // Random probe, enable and half-period activity.
    repeat (40 * 32 * DIV) begin
      if ($urandom_range(0, 3) == 0) sig = ~sig;
      if ($urandom_range(0, 199) == 0) tp_en = ~tp_en;
      if ($urandom_range(0, 149) == 0) tp_half = 16'($urandom_range(0, 6));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sig_deser.md
Name: sig_deser

Overview:
- Front-end capture stage that feeds the frequency/duty/pulse-width measurement and 7-segment display block.
- Synchronises the asynchronous probe input and samples it every DIV clocks.
- Packs 32 consecutive samples into a word, oldest sample in bit 0 and newest in bit 31.
- Presents each word on dsq0 together with a word clock pclk; the consumer captures dsq0 on the falling edge of pclk.
- A built-in square-wave test-pattern generator replaces the probe input for bring-up and self-test.

Parameters:
- DIV, 1, clk cycles per sample; legal range 1..65535.
- SYNC_STAGES, 2, synchroniser depth on sig; legal range 2..4.

Ports:
- clk  input  1  system clock. One clock; reset is asynchronous and active-high.
- rst  input  1  asynchronous active-high reset.
- sig  input  1  asynchronous probe signal.
- tp_en  input  1  test-pattern enable; takes effect only at a word boundary.
- tp_half  input  16  test-pattern half period, in samples; 0 is treated as 1.
- dsq0  output  32  packed sample word; bit0 is the oldest sample, bit31 the newest.
- pclk  output  1  word clock; rises when dsq0 updates, falls mid-word.
- wvalid  output  1  low until the first complete word has been delivered after reset, then high.

Behaviour:
- Reset (async, rst=1): synchroniser, div_cnt, bit_cnt, shreg, dsq0, pclk, wvalid, tp state all cleared to 0. FSM returns to FILL.
- Synchroniser: SYNC_STAGES flops clocked by clk. sync_out is sig delayed by SYNC_STAGES cycles.
- Strobe generation:
  - div_cnt counts 0..DIV-1 and wraps.
  - stb=1 on the cycle where div_cnt==DIV-1.
  - With DIV=1, stb is high every cycle.
- Sample source:
  - src = tp_act ? tp_bit : sync_out.
  - tp_act is a copy of tp_en, loaded only on the strobe that completes a word. A word is never a mix of probe and pattern samples.
- Test pattern:
  - On the word-boundary strobe where tp_act goes 0->1: tp_bit<=1, tp_cnt<=0.
  - On every other strobe while tp_act=1: tp_cnt increments. When tp_cnt reaches max(tp_half,1)-1, tp_bit toggles and tp_cnt clears.
  - tp_half is read live; a change applies from the next comparison.
- Shift path:
  - On stb: shreg <= {src, shreg[31:1]} and bit_cnt increments, wrapping 31->0.
  - On stb with bit_cnt==31: dsq0 <= {src, shreg[31:1]}, pclk<=1, wvalid<=1.
- pclk timing:
  - pclk<=0 on the stb where bit_cnt==15.
  - Result: pclk is high for 16 samples and low for 16; period is 32*DIV clk cycles.
  - dsq0 changes only at the pclk rising edge and is stable for 16*DIV cycles around the falling edge.
- FSM:
  - FILL: pclk=0 and dsq0=0 until the first word completes.
  - FILL -> RUN on the first word completion.
  - RUN stays in RUN until reset.
- Latency:
  - A sig transition reaches shreg at the first stb at least SYNC_STAGES+1 cycles later.
  - The first dsq0 word appears 32*DIV cycles after reset deassertion, plus 0 or 1 cycle for register alignment.
- Boundaries:
  - tp_en toggling mid-word: ignored until the word boundary.
  - tp_half=0: behaves as tp_half=1.
  - DIV=1: pclk high 16 cycles, low 16 cycles.
  - Reset asserted mid-word: partial word discarded, pclk forced 0 immediately (async), wvalid cleared.
  - Bit-order continuity: dsq0[31] of word N immediately precedes dsq0[0] of word N+1, so the downstream edge counter can chain words seamlessly.

Test Plan:
1. DIV=1, tp_en=1, tp_half=16, after reset -> first word after enable latches is 32'h0000FFFF; every later word is 32'h0000FFFF; pclk period 32 cycles, 16 high.
2. DIV=1, tp_en=1, tp_half=4 -> dsq0=32'h0F0F0F0F. Then tp_half=1 -> words settle to 32'h55555555, with at most one transition word.
3. tp_en=0, sig held 1 -> after SYNC_STAGES+32 cycles dsq0=32'hFFFFFFFF. Then sig=0 mid-word -> one mixed word with low bits 1 and high bits 0, then 32'h00000000.
4. DIV=4, tp_en=1, tp_half=8 -> pclk period 128 cycles; dsq0=32'h00FF00FF; dsq0 constant for 64 cycles either side of each pclk fall.
5. tp_en raised at bit_cnt=10 -> the current word stays probe data; the pattern starts exactly at bit0 of the next word.
6. rst pulsed at bit_cnt=20 in RUN -> pclk=0, dsq0=0, wvalid=0 immediately; next word appears 32*DIV cycles after release.
